// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// and driving datapath mux selects, write enables and ALU control.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRd    = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWr    = 4'd5;
    localparam logic [3:0] StExecute  = 4'd6;
    localparam logic [3:0] StAluWb    = 4'd7;
    localparam logic [3:0] StBranch   = 4'd8;
    localparam logic [3:0] StAddiExec = 4'd9;
    localparam logic [3:0] StAddiWb   = 4'd10;
    localparam logic [3:0] StJump     = 4'd11;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    logic [3:0] state_q, state_d;
    logic       pcwrite, branch;
    logic       memwrite_m, irwrite_m, regwrite_m;
    logic [2:0] funct_alu;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:    state_d = StMemWb;
            StExecute:  state_d = StAluWb;
            StAddiExec: state_d = StAddiWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = 3'b010;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite_m = 1'b0;
        irwrite_m  = 1'b0;
        regwrite_m = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (state_q)
            StFetch: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite_m  = 1'b1;
                pcwrite    = 1'b1;
            end
            StDecode: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            StMemAdr, StAddiExec: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                memtoreg   = 1'b1;
                regwrite_m = 1'b1;
            end
            StMemWr: begin
                iord       = 1'b1;
                memwrite_m = 1'b1;
            end
            StExecute: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            StAluWb: begin
                regdst     = 1'b1;
                regwrite_m = 1'b1;
            end
            StBranch: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            StAddiWb: regwrite_m = 1'b1;
            StJump: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every write enable so an interrupted instruction commits nothing.
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign memwrite = memwrite_m & ~reset;
    assign irwrite  = irwrite_m & ~reset;
    assign regwrite = regwrite_m & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected outputs go through a scoreboard queue
// and are compared against the DUT mid-cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [18:0] vec;
    } exp_t;
    exp_t sb[$];

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected output vector for a state, from the per-state output table.
    function automatic logic [18:0] ev(input logic [3:0] st, input logic [2:0] ex_alu,
                                       input logic z, input logic rst);
        logic pw, br, mw, ir, rw, io, m2r, rd, sa;
        logic [1:0] sb_, ps;
        logic [2:0] al;
        {pw, br, mw, ir, rw, io, m2r, rd, sa} = '0;
        sb_ = 2'b00; ps = 2'b00; al = 3'b000;
        case (st)
            4'd0:  begin sb_ = 2'b01; al = 3'b010; ir = 1; pw = 1; end
            4'd1:  begin sb_ = 2'b11; al = 3'b010; end
            4'd2, 4'd9: begin sa = 1; sb_ = 2'b10; al = 3'b010; end
            4'd3:  io = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin sa = 1; al = ex_alu; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; al = 3'b110; ps = 2'b01; br = 1; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {st, (pw | (br & z)) & ~rst, mw & ~rst, ir & ~rst, rw & ~rst,
                io, m2r, rd, sa, sb_, ps, al};
    endfunction

    // One cycle: drive inputs, queue the expectation, then check mid-cycle.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input logic [3:0] exp_st,
                       input logic [2:0] ex_alu);
        exp_t e;
        logic [18:0] obs;
        @(negedge clk);
        reset = rst; op = o; funct = f; zero = z;
        sb.push_back('{tag, ev(exp_st, ex_alu, z, rst)});
        #2;
        obs = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, alucontrol};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                errors++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.vec);
            end
        end
    endtask

    logic [5:0] rf[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [2:0] ra[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        @(posedge clk);
        cyc("rst_a", 1, 6'b0, 6'b0, 0, 4'd0, 3'b0);
        cyc("rst_b", 1, 6'b0, 6'b0, 0, 4'd0, 3'b0);

        cyc("lw_fetch",  0, 6'b100011, 6'b0, 0, 4'd0, 3'b0);
        cyc("lw_dec",    0, 6'b100011, 6'b0, 0, 4'd1, 3'b0);
        cyc("lw_adr",    0, 6'b100011, 6'b0, 0, 4'd2, 3'b0);
        cyc("lw_rd",     0, 6'b100011, 6'b0, 1, 4'd3, 3'b0);
        cyc("lw_wb",     0, 6'b100011, 6'b0, 0, 4'd4, 3'b0);
        cyc("sw_fetch",  0, 6'b101011, 6'b0, 0, 4'd0, 3'b0);
        cyc("sw_dec",    0, 6'b101011, 6'b0, 0, 4'd1, 3'b0);
        cyc("sw_adr",    0, 6'b101011, 6'b0, 0, 4'd2, 3'b0);
        cyc("sw_wr",     0, 6'b101011, 6'b0, 0, 4'd5, 3'b0);

        for (int i = 0; i < 6; i++) begin
            cyc("r_fetch", 0, 6'b000000, rf[i], 0, 4'd0, 3'b0);
            cyc("r_dec",   0, 6'b000000, rf[i], 0, 4'd1, 3'b0);
            cyc("r_exec",  0, 6'b000000, rf[i], 1, 4'd6, ra[i]);
            cyc("r_wb",    0, 6'b000000, rf[i], 0, 4'd7, 3'b0);
        end

        cyc("beq1_fetch", 0, 6'b000100, 6'b0, 0, 4'd0, 3'b0);
        cyc("beq1_dec",   0, 6'b000100, 6'b0, 1, 4'd1, 3'b0);
        cyc("beq1_taken", 0, 6'b000100, 6'b0, 1, 4'd8, 3'b0);
        cyc("beq2_fetch", 0, 6'b000100, 6'b0, 0, 4'd0, 3'b0);
        cyc("beq2_dec",   0, 6'b000100, 6'b0, 0, 4'd1, 3'b0);
        cyc("beq2_nt",    0, 6'b000100, 6'b0, 0, 4'd8, 3'b0);

        cyc("addi_fetch", 0, 6'b001000, 6'b0, 0, 4'd0, 3'b0);
        cyc("addi_dec",   0, 6'b001000, 6'b0, 0, 4'd1, 3'b0);
        cyc("addi_exec",  0, 6'b001000, 6'b0, 0, 4'd9, 3'b0);
        cyc("addi_wb",    0, 6'b001000, 6'b0, 0, 4'd10, 3'b0);
        cyc("j_fetch",    0, 6'b000010, 6'b0, 0, 4'd0, 3'b0);
        cyc("j_dec",      0, 6'b000010, 6'b0, 0, 4'd1, 3'b0);
        cyc("j_jump",     0, 6'b000010, 6'b0, 1, 4'd11, 3'b0);
        cyc("ill_fetch",  0, 6'b111111, 6'b0, 0, 4'd0, 3'b0);
        cyc("ill_dec",    0, 6'b111111, 6'b0, 0, 4'd1, 3'b0);

        cyc("mr_fetch", 0, 6'b100011, 6'b0, 0, 4'd0, 3'b0);
        cyc("mr_dec",   0, 6'b100011, 6'b0, 0, 4'd1, 3'b0);
        cyc("mr_adr",   0, 6'b100011, 6'b0, 0, 4'd2, 3'b0);
        cyc("mr_rd",    1, 6'b100011, 6'b0, 0, 4'd3, 3'b0);
        cyc("mr_resume", 0, 6'b100011, 6'b0, 0, 4'd0, 3'b0);
        cyc("mr_dec2",  0, 6'b000000, 6'b0, 0, 4'd1, 3'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS-subset datapath. Moore state machine that sequences fetch/decode/execute/memory/writeback and drives the shared ALU's 3-bit `alucontrol` in the encoding that ALU consumes:
- bit 2 inverts `b` with carry-in 1;
- bits 1:0 select AND, OR, sum or slt.

It also drives all datapath muxes and write enables for the single-memory multicycle datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  instruction opcode, `instr[31:26]`, taken from the instruction register
- funct  in  6  `instr[5:0]`, from the instruction register
- zero  in  1  ALU result == 0, same cycle
- pcen  out  1  PC register enable
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memtoreg  out  1  write data: 0=ALUOut, 1=Data register
- regdst  out  1  destination register: 0=rt, 1=rd
- alusrca  out  1  ALU A: 0=PC, 1=A register
- alusrcb  out  2  ALU B: 00=B register, 01=constant 4, 10=SignImm, 11=SignImm<<2
- pcsrc  out  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state code, for debug and verification

## Operation
State codes:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
- Codes 12–15 are illegal and go to FETCH on the next edge. All outputs are 0 in an illegal state.

Transitions:
- FETCH→DECODE.
- DECODE on `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - any other `op` → FETCH, executed as a NOP
- MEMADR→MEMRD if `op`=lw, else →MEMWR.
- MEMRD→MEMWB. EXECUTE→ALUWB. ADDIEXEC→ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all →FETCH.

Per-state outputs (anything not listed is 0):
- FETCH: alusrcb=01, alucontrol=010, irwrite=1, pcwrite=1
- DECODE: alusrcb=11, alucontrol=010
- MEMADR, ADDIEXEC: alusrca=1, alusrcb=10, alucontrol=010
- MEMRD: iord=1
- MEMWB: memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=1
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from `funct`:
  - 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111
  - any other `funct` → 010
- ALUWB: regdst=1, regwrite=1
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1
- ADDIWB: regwrite=1
- JUMP: pcsrc=10, pcwrite=1

PC enable:
- `pcen = pcwrite | (branch & zero)`.
- `pcwrite` and `branch` are internal. `pcen` is the only Mealy path (through `zero`).

## Timing
- Reset:
  - While `reset`=1, pcen, irwrite, memwrite and regwrite are forced to 0.
  - The first rising edge with `reset`=1 loads FETCH.
  - After release, `state`=0 and FETCH outputs are active; the first instruction fetch commits on the first edge with `reset`=0.
- Reset mid-instruction: FETCH is loaded on that edge regardless of the current state, and no write enable is asserted in that cycle.
- Cycles per instruction:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown `op` 2.
- `op` and `funct` are sampled combinationally. They must be stable from DECODE through the last state of the instruction; the instruction register guarantees this because `irwrite`=1 only in FETCH.
- `zero` is consumed only in BRANCH. `zero` toggling in any other state has no effect on `pcen`.
- One state per cycle. There are no stalls and no handshake.

## Test plan
- Reset held 3 cycles, then released: `state`=0 and pcen=irwrite=regwrite=memwrite=0 during reset; the first cycle after release has pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
- lw (op=100011): states 0,1,2,3,4 then 0. Check iord=1 in state 3, and memtoreg=1 with regwrite=1 in state 4. Repeat with sw (op=101011): states 0,1,2,5,0 with memwrite=1 only in state 5.
- R-type (op=000000) with funct 100000, 100010, 100100, 100101, 101010, 111111: alucontrol in EXECUTE is 010, 110, 000, 001, 111, 010 respectively; ALUWB has regdst=1, regwrite=1.
- beq (op=000100): with zero=1 in BRANCH, pcen=1, pcsrc=01, alucontrol=110. With zero=0, pcen=0. With zero=1 pulsed during DECODE, pcen stays 0 in DECODE.
- addi (op=001000) then j (op=000010): states 0,1,9,10,0,1,11,0. JUMP has pcen=1, pcsrc=10. Illegal op=111111: states 0,1,0 with no write enables asserted.
- Reset asserted in MEMRD of an lw: the next state is 0, no regwrite ever occurs for that lw, and normal fetch resumes after release.
